// File: rtl/pipelined_nadder.sv
// Pipelined N-bit adder/subtractor: STAGES registered carry chunks, valid/ready handshake with a global stall.
// Optional macro PADDER_SAT_EN clamps the result to the signed range on overflow.
module pipelined_nadder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int C = (STAGES > 0) ? N / STAGES : N;

  if (STAGES < 1 || STAGES > N || ((STAGES > 0) ? (N % STAGES) : 1) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_nadder: STAGES must be in 1..N and divide N");
  end

  logic advance_s;

  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // Stage k consumes the low chunk of the remaining operand bits and forwards the rest.
    localparam int LO = k * C;
    localparam int RW = N - LO;

    logic              v_in_s;
    logic              c_in_s;
    logic [RW-1:0]     a_in_s;
    logic [RW-1:0]     b_in_s;
    logic [C:0]        chunk_s;
    logic [LO+C-1:0]   s_next_s;
    logic [LO+C-1:0]   s_final_s;
    logic              v_r;
    logic              c_r;
    logic [LO+C-1:0]   s_r;

    if (k == 0) begin : g_head
      assign v_in_s   = in_valid;
      assign c_in_s   = sub ? 1'b1 : cin;
      assign a_in_s   = a;
      assign b_in_s   = sub ? ~b : b;
      assign s_next_s = chunk_s[C-1:0];
    end else begin : g_tail
      assign v_in_s   = g_stage[k-1].v_r;
      assign c_in_s   = g_stage[k-1].c_r;
      assign a_in_s   = g_stage[k-1].g_mid.a_r;
      assign b_in_s   = g_stage[k-1].g_mid.b_r;
      assign s_next_s = {chunk_s[C-1:0], g_stage[k-1].s_r};
    end

    assign chunk_s = {1'b0, a_in_s[C-1:0]} + {1'b0, b_in_s[C-1:0]} + {{C{1'b0}}, c_in_s};

    if (k < STAGES - 1) begin : g_mid
      logic [RW-C-1:0] a_r;
      logic [RW-C-1:0] b_r;

      assign s_final_s = s_next_s;

      // Carry the unused high operand bits forward (b already inverted for subtract).
      always_ff @(posedge clk) begin
        if (reset) begin
          a_r <= {(RW-C){1'b0}};
          b_r <= {(RW-C){1'b0}};
        end else if (advance_s) begin
          a_r <= a_in_s[RW-1:C];
          b_r <= b_in_s[RW-1:C];
        end
      end
    end else begin : g_last
      logic ovf_next_s;
      logic ovf_r;

      assign ovf_next_s = (a_in_s[RW-1] == b_in_s[RW-1]) && (s_next_s[N-1] != a_in_s[RW-1]);

`ifdef PADDER_SAT_EN
      // Overflow direction follows the common operand sign.
      always_comb begin
        if (ovf_next_s) begin
          s_final_s = a_in_s[RW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
          s_final_s = s_next_s;
        end
      end
`else
      assign s_final_s = s_next_s;
`endif

      // Registered signed-overflow flag of the output stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_r <= 1'b0;
        end else if (advance_s) begin
          ovf_r <= ovf_next_s;
        end
      end
    end

    // Per-stage valid, carry and low result bits; every stage holds together on a stall.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= {(LO+C){1'b0}};
      end else if (advance_s) begin
        v_r <= v_in_s;
        c_r <= chunk_s[C];
        s_r <= s_final_s;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign s         = g_stage[STAGES-1].s_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_nadder.sv
// Self-checking bench for pipelined_nadder (N=32, STAGES=4) with a queue-based arithmetic reference model.
module tb_pipelined_nadder;

  localparam int N  = 32;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = 32'h0;
  logic [N-1:0]  b = 32'h0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  s;
  logic          cout;
  logic          ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t mon_beat;

  pipelined_nadder #(.N(N), .STAGES(ST)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mathematical result of a+b+cin or a-b on true integers, then wrapped / clamped.
  function automatic beat_t model(input logic [31:0] ia, input logic [31:0] ib, input logic ic, input logic is);
    beat_t  r;
    longint sa, sb, res, ua, ub;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    ua = longint'({32'h0, ia});
    ub = longint'({32'h0, ib});
    if (is) begin
      res    = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      res    = sa + sb + (ic ? 64'sd1 : 64'sd0);
      r.cout = ((ua + ub + (ic ? 64'sd1 : 64'sd0)) >>> 32) != 64'sd0;
    end
    r.ovf = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    r.s   = res[31:0];
`ifdef PADDER_SAT_EN
    if (res > 64'sd2147483647) r.s = 32'h7FFFFFFF;
    else if (res < -64'sd2147483648) r.s = 32'h80000000;
`endif
    r.cyc = cyc;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'h7FFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard capture: accepted beats into the model queue, emitted beats into the observed queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready === 1'b1) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid === 1'b1 && out_ready) begin
        mon_beat.s    = s;
        mon_beat.cout = cout;
        mon_beat.ovf  = ovf;
        mon_beat.cyc  = cyc;
        got_q.push_back(mon_beat);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic is, input logic ordy);
    in_valid  = v;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (s !== 32'h0) begin n_bad++; $display("FAIL reset_s: got %h want 00000000", s); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_directed();
    logic [31:0] ws[5];
    logic        wc[5];
    logic        wo[5];
    beat_t       g, e;
    int          first_cyc;
    ws[0] = 32'hFFFFFFFF; wc[0] = 1'b0; wo[0] = 1'b0;
    ws[1] = 32'h00000000; wc[1] = 1'b1; wo[1] = 1'b0;
    ws[2] = 32'hFFFFFFFE; wc[2] = 1'b0; wo[2] = 1'b0;
`ifdef PADDER_SAT_EN
    ws[3] = 32'h7FFFFFFF;
    ws[4] = 32'h80000000;
`else
    ws[3] = 32'h80000000;
    ws[4] = 32'h7FFFFFFF;
`endif
    wc[3] = 1'b0; wo[3] = 1'b1;
    wc[4] = 1'b1; wo[4] = 1'b1;
    exp_q.delete();
    got_q.delete();
    drive(1'b1, 32'h11111111, 32'hEEEEEEEE, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h11111111, 32'hEEEEEEEE, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (got_q.size() != 5) begin n_bad++; $display("FAIL directed_count: got %0d beats want 5", got_q.size()); end
    first_cyc = (got_q.size() > 0) ? got_q[0].cyc : 0;
    for (int i = 0; i < 5 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g.s !== ws[i] || g.cout !== wc[i] || g.ovf !== wo[i]) begin
        n_bad++;
        $display("FAIL directed_beat%0d: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b", i, g.s, g.cout, g.ovf, ws[i], wc[i], wo[i]);
      end
      n_cmp++;
      if (g.cyc - e.cyc != ST) begin n_bad++; $display("FAIL directed_latency%0d: got %0d want %0d", i, g.cyc - e.cyc, ST); end
      n_cmp++;
      if (g.cyc != first_cyc + i) begin n_bad++; $display("FAIL directed_consecutive%0d: got cycle %0d want %0d", i, g.cyc, first_cyc + i); end
    end
  endtask

  task automatic test_backpressure();
    int    i;
    beat_t g;
    exp_q.delete();
    got_q.delete();
    i = 0;
    for (int t = 0; t < 40 && (i < 6 || got_q.size() < 6); t++) begin
      in_valid  = (i < 6);
      a         = i;
      b         = 32'h1;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = !(t >= 4 && t <= 6);
      @(negedge clk);
      if (t >= 4 && t <= 6) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready t=%0d: got %b want 0", t, in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid t=%0d: got %b want 1", t, out_valid); end
        n_cmp++; if (s !== 32'h1) begin n_bad++; $display("FAIL stall_s t=%0d: got %h want 00000001", t, s); end
      end
      if (in_valid && in_ready === 1'b1) i++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got_q.size() != 6) begin n_bad++; $display("FAIL bp_count: got %0d beats want 6", got_q.size()); end
    for (int j = 0; j < 6 && got_q.size() > 0; j++) begin
      g = got_q.pop_front();
      n_cmp++;
      if (g.s !== 32'(j + 1) || g.cout !== 1'b0 || g.ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_order%0d: got s=%h cout=%b ovf=%b want s=%h cout=0 ovf=0", j, g.s, g.cout, g.ovf, 32'(j + 1));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (s !== 32'h0) begin n_bad++; $display("FAIL flush_s: got %h want 00000000", s); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost%0d: got out_valid=%b want 0", i, out_valid); end
    end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL flush_emitted: got %0d beats want 0", got_q.size()); end
  endtask

  task automatic test_random();
    int          sent;
    int          t;
    logic        held;
    logic [31:0] held_s;
    logic        held_c, held_o;
    beat_t       g, e;
    exp_q.delete();
    got_q.delete();
    sent = 0;
    held = 1'b0;
    held_s = 32'h0; held_c = 1'b0; held_o = 1'b0;
    for (t = 0; t < 3000 && (sent < 200 || got_q.size() != exp_q.size()); t++) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      cin       = $urandom_range(0, 1) != 0;
      sub       = $urandom_range(0, 1) != 0;
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || s !== held_s || cout !== held_c || ovf !== held_o) begin
          n_bad++;
          $display("FAIL rand_hold t=%0d: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b", t, out_valid, s, cout, ovf, held_s, held_c, held_o);
        end
      end
      held   = (out_valid === 1'b1) && !out_ready;
      held_s = s; held_c = cout; held_o = ovf;
      if (in_valid && in_ready === 1'b1) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (t >= 3000) begin n_bad++; $display("FAIL rand_timeout: sent %0d emitted %0d", sent, got_q.size()); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g.s !== e.s || g.cout !== e.cout || g.ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL rand_beat: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b", g.s, g.cout, g.ovf, e.s, e.cout, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_nadder.md
Name: pipelined_nadder

Overview:
- Parametrised successor to the combinational N-bit ripple adder.
- Splits the carry chain into STAGES registered chunks so wide adds close timing at the pipelined MIPS core clock.
- Adds subtraction, signed-overflow flag and a valid/ready handshake with backpressure.
- Sits in the ALU datapath as a drop-in for wide add/sub, and in the multi-cycle multiply/divide helpers.

Parameters:
- N, 32, operand/result width in bits.
- STAGES, 4, pipeline depth; legal range 1..N; N % STAGES == 0 is required (elaboration-time $fatal otherwise).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: a+b+cin; 1: a-b, i.e. a+~b+1, cin ignored
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- s  output  N  sum/difference
- cout  output  1  raw carry out of bit N-1; for sub, 1 means no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Chunk width is C = N/STAGES. Stage k (0..STAGES-1) adds bits [k*C +: C] using the carry registered by stage k-1. Stage 0 uses carry-in = sub ? 1 : cin.
- Stage k also registers:
  - the already-computed low result bits;
  - the not-yet-used high operand bits (b already conditionally inverted);
  - a valid bit.
- Global advance = !out_valid | out_ready. When advance=1, every stage register shifts one step. When advance=0, all stage registers hold.
- in_ready = advance (combinational from out_valid/out_ready). A beat is accepted iff in_valid & in_ready.
- Latency is exactly STAGES cycles from acceptance to out_valid, with zero stalls. Throughput is 1 beat/cycle.
- s, cout and ovf are registered outputs of the last stage. They must be stable while out_valid=1 and out_ready=0.
- ovf = (A_msb == B'_msb) & (S_msb != A_msb), where B' is the conditionally inverted b.
- Bubbles are allowed: a stage with valid=0 may carry garbage data, but its valid must be 0.
- Ordering is strictly FIFO. No beat is dropped or duplicated under any out_ready pattern.
- Simultaneous accept and emit in the same cycle is legal when out_ready=1 at full occupancy.
- Reset (synchronous):
  - all stage valid bits clear; out_valid=0, s=0, cout=0, ovf=0;
  - in_ready=1 in the first cycle after reset;
  - reset asserted mid-operation flushes every in-flight beat, and none emerges afterwards.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Carry wrap-around: a full-width carry out only sets cout; it never feeds back.

Optional Feature:
- Macro: PADDER_SAT_EN.
- When defined, s is clamped on signed overflow: positive overflow gives 0x7F..F and negative overflow gives 0x80..0. ovf is still reported as 1 and cout is still the raw carry. Clamp is applied in the last stage, with no added latency.
- When undefined, s is the wrapped result and no clamp logic is generated.

Test Plan:
- Add, cin=0 (N=32, STAGES=4): a=0x11111111, b=0xEEEEEEEE, sub=0, cin=0 -> after 4 cycles out_valid=1, s=0xFFFFFFFF, cout=0, ovf=0.
- Add, cin=1: same operands with cin=1 -> s=0x00000000, cout=1, ovf=0. Back-to-back with the previous beat, results emerge on consecutive cycles.
- Subtract: a=5, b=7, sub=1, cin=1 -> s=0xFFFFFFFE, cout=0, ovf=0. Then a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> s=0x80000000, ovf=1 (with PADDER_SAT_EN: s=0x7FFFFFFF, ovf=1).
- Backpressure: stream 6 beats a=i, b=1 (i=0..5) while holding out_ready=0 for cycles 5..7.
  - in_ready=0 during the stall;
  - s stays at 0x1 for the whole stall;
  - final outputs are 1,2,3,4,5,6 in order, with none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert reset for 1 cycle at cycle 2 -> out_valid=0 and s=0 the next cycle; no result appears over the following 8 cycles; in_ready=1.
- Saturate negative (PADDER_SAT_EN): a=0x80000000, b=1, sub=1 -> s=0x80000000, ovf=1, cout=1.
